xor_frame_parity: RTL and testbench

Parametrised sequential successor to the two-input XOR gate. It accepts a stream of WIDTH-bit words grouped into frames. For each frame it accumulates the bitwise XOR checksum of all words, then reduces that checksum serially, one bit per clock, to a single parity bit. It is the team's first clocked XOR block with valid/ready handshakes and sits between a word source and a checksum/parity consumer.

---
 rtl/xor_frame_parity.sv | 106 ++++++++++
 tb/tb_xor_frame_parity.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/xor_frame_parity.sv
// Frame XOR checksum with serial parity reduction.
// Words are folded into a checksum; the checksum is then shifted out one bit per clock into a parity bit.
module xor_frame_parity #(
  parameter int WIDTH = 8,
  parameter int ODD   = 0,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_check,
  output logic             out_parity,
  output logic [CW-1:0]    out_count
);

  localparam int   BW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic ODD_BIT = 1'(ODD);

  typedef enum logic [1:0] {ACCUM, REDUCE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] check_q, check_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             par_q, par_d;

  // Word count sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    shreg_d = shreg_q;
    check_d = check_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    par_d   = par_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          acc_d = acc_q ^ in_data;
          cnt_d = sat_inc(cnt_q);
          if (in_last) begin
            check_d = acc_q ^ in_data;
            shreg_d = acc_q ^ in_data;
            par_d   = ODD_BIT;
            bit_d   = '0;
            state_d = REDUCE;
          end
        end
      end
      REDUCE: begin
        par_d   = par_q ^ shreg_q[0];
        shreg_d = shreg_q >> 1;
        bit_d   = bit_q + 1'b1;
        if (bit_q == BW'(WIDTH - 1)) state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          par_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      shreg_q <= '0;
      check_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      shreg_q <= shreg_d;
      check_q <= check_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
    end
  end

  // in_ready is gated by rst_n so the source never sees a handshake during reset.
  assign in_ready   = rst_n & (state_q == ACCUM);
  assign out_valid  = (state_q == HOLD);
  assign out_check  = check_q;
  assign out_parity = par_q;
  assign out_count  = cnt_q;

endmodule

// File: tb/tb_xor_frame_parity.sv
// Directed bench for xor_frame_parity: even/odd 8-bit instances plus a 4-bit, 2-bit-counter instance.
module tb_xor_frame_parity;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid, in_last, out_ready;
  logic [7:0] in_data;
  logic       rdy0, ov0, par0, rdy1, ov1, par1;
  logic [7:0] chk0, cnt0, chk1, cnt1;

  logic       v2, l2, or2, rdy2, ov2, par2;
  logic [3:0] d2, chk2;
  logic [1:0] cnt2;

  int nchecks = 0;
  int nerr    = 0;
  int lat;

  xor_frame_parity #(.WIDTH(8), .ODD(0), .CW(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .out_check(chk0),
    .out_parity(par0), .out_count(cnt0));

  xor_frame_parity #(.WIDTH(8), .ODD(1), .CW(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .out_check(chk1),
    .out_parity(par1), .out_count(cnt1));

  xor_frame_parity #(.WIDTH(4), .ODD(0), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
    .in_last(l2), .out_valid(ov2), .out_ready(or2), .out_check(chk2),
    .out_parity(par2), .out_count(cnt2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_ov0(output int n);
    n = 0;
    while (ov0 !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic wait_ov2(output int n);
    n = 0;
    while (ov2 !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic release0();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    v2 = 1'b0; l2 = 1'b0; d2 = '0; or2 = 1'b0;
    step();
    step();
    check("rst_ready_low", rdy0, 0);
    check("rst_valid", ov0, 0);
    check("rst_check", chk0, 0);
    check("rst_count", cnt0, 0);
    check("rst_parity", par0, 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", rdy0, 1);

    // single word A5
    send0(8'hA5, 1'b1);
    check("single_ready_reduce", rdy0, 0);
    wait_ov0(lat);
    check("single_latency", lat, 8);
    check("single_check", chk0, 8'hA5);
    check("single_parity_even", par0, 0);
    check("single_parity_odd", par1, 1);
    check("single_count", cnt0, 1);
    release0();
    check("single_valid_clr", ov0, 0);
    check("single_ready_back", rdy0, 1);

    // three-word frame
    send0(8'h0F, 1'b0);
    send0(8'hF0, 1'b0);
    send0(8'h01, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("three_ready_reduce", rdy0, 0);
      if (ov0 === 1'b1) break;
      step();
    end
    check("three_valid", ov0, 1);
    check("three_check", chk0, 8'hFE);
    check("three_parity", par0, 1);
    check("three_parity_odd", par1, 0);
    check("three_count", cnt0, 3);

    // backpressure with junk on the input
    in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", ov0, 1);
      check("bp_ready", rdy0, 0);
      check("bp_check", chk0, 8'hFE);
      check("bp_parity", par0, 1);
      check("bp_count", cnt0, 3);
    end
    in_valid = 1'b0; in_last = 1'b0;
    release0();
    check("bp_release_valid", ov0, 0);
    check("bp_release_ready", rdy0, 1);
    check("bp_release_count", cnt0, 0);

    // reset on the third REDUCE edge
    send0(8'h55, 1'b1);
    step();
    step();
    rst_n = 1'b0;
    step();
    check("mid_rst_check", chk0, 0);
    check("mid_rst_count", cnt0, 0);
    check("mid_rst_valid", ov0, 0);
    check("mid_rst_ready", rdy0, 0);
    rst_n = 1'b1;
    #1;
    check("mid_rst_ready_back", rdy0, 1);
    step();
    check("mid_rst_no_valid", ov0, 0);

    // back-to-back frames
    send0(8'h33, 1'b1);
    wait_ov0(lat);
    check("b2b_latency", lat, 8);
    check("b2b_check", chk0, 8'h33);
    check("b2b_parity", par0, 0);
    check("b2b_count", cnt0, 1);
    release0();
    check("b2b_ready_back", rdy0, 1);
    send0(8'h80, 1'b1);
    wait_ov0(lat);
    check("b2b2_check", chk0, 8'h80);
    check("b2b2_parity", par0, 1);
    check("b2b2_count", cnt0, 1);
    release0();

    // counter saturation: WIDTH 4, CW 2
    for (int i = 0; i < 5; i++) begin
      check("sat_ready", rdy2, 1);
      v2 = 1'b1; d2 = 4'h1; l2 = (i == 4);
      step();
    end
    v2 = 1'b0; l2 = 1'b0;
    wait_ov2(lat);
    check("sat_latency", lat, 4);
    check("sat_count", cnt2, 3);
    check("sat_check", chk2, 4'h1);
    check("sat_parity", par2, 1);
    or2 = 1'b1;
    step();
    or2 = 1'b0;
    check("sat_ready_back", rdy2, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
